// File: rtl/led_pkg.sv
// Shared state encodings and width helper for the LED blink-code arbiter.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_e;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned clog2w(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Timing prescaler: pulses tick once every TICK_DIV cycles; clr restarts the count
// so a phase entered with clr lasts an exact multiple of TICK_DIV cycles.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = clog2w(TICK_DIV);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  always_comb begin
    tick  = (pre_q == PW'(TICK_DIV - 1));
    pre_d = pre_q + 1'b1;
    if (clr || tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/led_code_arbiter.sv
// Round-robin share of one LED between NREQ blink-code requesters; grant one cycle
// after an eligible request is seen in IDLE, held until the sequence's done pulse.
module led_code_arbiter
  import led_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TICK_DIV  = 50000,
  parameter int ON_TICKS  = 10,
  parameter int OFF_TICKS = 10,
  parameter int GAP_TICKS = 40,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] count,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic                  led
);

  localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T      = (MAX_ON_OFF > GAP_TICKS) ? MAX_ON_OFF : GAP_TICKS;
  localparam int PTR_W      = clog2w(NREQ);
  localparam int PH_W       = clog2w(MAX_T);

  led_state_e       state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             done_q, done_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic [PH_W-1:0]  phase_q, phase_d;

  logic             tick;
  logic             clr;
  logic [NREQ-1:0]  elig;
  logic [CNT_W-1:0] cnt_fld [NREQ];
  logic             hit;
  logic [PTR_W-1:0] win;
  logic [PH_W-1:0]  phase_last;
  logic             phase_end;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  // Zero-count requests are never eligible, so they can never win a grant.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_fld[i] = count[i*CNT_W +: CNT_W];
      elig[i]    = req[i] && (count[i*CNT_W +: CNT_W] != '0);
    end
  end

  // Search starts just past the last owner so a held request falls to the back.
  always_comb begin
    hit = 1'b0;
    win = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!hit && elig[PTR_W'((int'(ptr_q) + k) % NREQ)]) begin
        hit = 1'b1;
        win = PTR_W'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    case (state_q)
      ST_ON:   phase_last = PH_W'(ON_TICKS - 1);
      ST_OFF:  phase_last = PH_W'(OFF_TICKS - 1);
      default: phase_last = PH_W'(GAP_TICKS - 1);
    endcase
    phase_end = tick && (phase_q == phase_last);
    clr       = (state_q == ST_IDLE) || phase_end;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    pulse_d = pulse_q;
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = phase_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ON;
          grant_d = NREQ'(1) << win;
          ptr_d   = win;
          pulse_d = cnt_fld[win];
        end
      end
      ST_ON: begin
        if (phase_end) begin
          pulse_d = pulse_q - 1'b1;
          state_d = (pulse_q != CNT_W'(1)) ? ST_OFF : ST_GAP;
        end
      end
      ST_OFF: begin
        if (phase_end) begin
          state_d = ST_ON;
        end
      end
      default: begin
        if (phase_end) begin
          state_d = ST_IDLE;
          grant_d = '0;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= 1'b0;
      ptr_q   <= PTR_W'(NREQ - 1);
      pulse_q <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      pulse_q <= pulse_d;
      phase_q <= phase_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);
  assign led   = (state_q == ST_ON);

endmodule

// File: tb/tb_led_code_arbiter.sv
// Directed bench for led_code_arbiter: expected owners/counts queued at stimulus time,
// popped and compared when the DUT grants and completes each blink sequence.
module tb_led_code_arbiter;

  localparam int NREQ      = 4;
  localparam int TICK_DIV  = 4;
  localparam int ON_TICKS  = 2;
  localparam int OFF_TICKS = 1;
  localparam int GAP_TICKS = 3;
  localparam int CNT_W     = 4;
  localparam int ON_CYC    = ON_TICKS * TICK_DIV;
  localparam int OFF_CYC   = OFF_TICKS * TICK_DIV;
  localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] count;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic                  led;

  led_code_arbiter #(
    .NREQ     (NREQ),
    .TICK_DIV (TICK_DIV),
    .ON_TICKS (ON_TICKS),
    .OFF_TICKS(OFF_TICKS),
    .GAP_TICKS(GAP_TICKS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .count(count),
    .grant(grant),
    .busy (busy),
    .done (done),
    .led  (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int c;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  bit   after_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_led(input int c, input int k);
    return (k < c * (ON_CYC + OFF_CYC) - OFF_CYC) && ((k % (ON_CYC + OFF_CYC)) < ON_CYC);
  endfunction

  function automatic int exp_len(input int c);
    return c * ON_CYC + (c - 1) * OFF_CYC + GAP_CYC;
  endfunction

  // Steps until a grant appears; leaves the bench at the first granted cycle.
  task automatic begin_seq(output exp_t e, output bit got, output int waited);
    got    = 1'b0;
    waited = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      waited++;
      if (after_done) begin
        check("done_one_cycle", done, 0);
        after_done = 1'b0;
      end
      if (grant != '0) begin
        got = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    check($sformatf("grant_r%0d", e.idx), grant, 32'd1 << e.idx);
    check("busy_at_grant", busy, 1);
  endtask

  task automatic track(input int drop_k, input logic [NREQ-1:0] drop_req,
                       input logic [NREQ*CNT_W-1:0] drop_count, output int waited);
    exp_t e;
    bit   got;
    int   led_err, own_err, pulses, done_k;
    logic prev_led;
    begin_seq(e, got, waited);
    led_err  = 0;
    own_err  = 0;
    pulses   = 0;
    done_k   = -1;
    prev_led = 1'b0;
    if (got) begin
      for (int k = 0; k < exp_len(e.c) + 10; k++) begin
        if (k > 0) step();
        if (done) begin
          done_k = k;
          break;
        end
        if (led !== exp_led(e.c, k)) led_err++;
        if (grant !== (NREQ'(1) << e.idx) || busy !== 1'b1) own_err++;
        if (led && !prev_led) pulses++;
        prev_led = led;
        if (k == drop_k) begin
          req   = drop_req;
          count = drop_count;
        end
      end
    end
    check($sformatf("seq_len_r%0d_c%0d", e.idx, e.c), done_k, exp_len(e.c));
    check("led_pattern_errs", led_err, 0);
    check("grant_held_errs", own_err, 0);
    check($sformatf("pulses_c%0d", e.c), pulses, e.c);
    check("grant_at_done", grant, 0);
    check("busy_at_done", busy, 0);
    check("led_at_done", led, 0);
    after_done = 1'b1;
  endtask

  initial begin
    exp_t e;
    bit   got;
    int   waited, bad, dn;

    // Reset with every requester asking.
    rst   = 1'b1;
    req   = 4'b1111;
    count = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_led", led, 0);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    rst = 1'b0;
    sb.push_back('{0, 1});
    track(-1, req, count, waited);
    check("first_grant_latency", waited, 1);
    req = '0;

    // Single three-pulse code on requester 2.
    count = 16'h0300;
    req   = 4'b0100;
    sb.push_back('{2, 3});
    track(-1, req, count, waited);
    req = '0;

    // Reset during the second ON pulse.
    req = 4'b0100;
    sb.push_back('{2, 3});
    begin_seq(e, got, waited);
    for (int k = 1; k <= 14; k++) step();
    check("second_on_led", led, 1);
    rst = 1'b1;
    req = '0;
    step();
    check("midrst_led", led, 0);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    dn  = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dn++;
    end
    check("midrst_no_done", dn, 0);

    // Round robin with requests held; pointer restarted by the reset above.
    count = 16'h1111;
    req   = 4'b1011;
    sb.push_back('{0, 1});
    sb.push_back('{1, 1});
    sb.push_back('{3, 1});
    sb.push_back('{0, 1});
    for (int i = 0; i < 4; i++) track(-1, req, count, waited);
    req = '0;

    // Zero-count requester 1 is ignored; requester 3 drops req and count changes.
    count = 16'h2000;
    req   = 4'b1010;
    sb.push_back('{3, 2});
    track(5, 4'b0010, 16'h5000, waited);
    after_done = 1'b0;
    bad = 0;
    dn  = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy || grant != '0) bad++;
      if (done) dn++;
    end
    check("zero_count_idle", bad, 0);
    check("zero_count_no_done", dn, 0);
    req = '0;

    // Largest legal count.
    count = 16'h000F;
    req   = 4'b0001;
    sb.push_back('{0, 15});
    track(-1, req, count, waited);
    req = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_code_arbiter.md
Name: led_code_arbiter

Overview:
- Shares the single board LED between NREQ requesters; each requester asks to flash a "blink code" of N pulses.
- Round-robin arbitration, then sequencing of the LED through ON/OFF pulses and a trailing gap, timed by an internal tick prescaler.
- Sits between status sources (error flags, heartbeat, boot stages) and the LED pin, replacing direct free-running blinkers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TICK_DIV, 50000, clk cycles per timing tick (>=2).
- ON_TICKS, 10, ticks LED is high per pulse (>=1).
- OFF_TICKS, 10, ticks LED is low between pulses (>=1).
- GAP_TICKS, 40, ticks LED is low after the last pulse, before done (>=1).
- CNT_W, 4, width of each pulse-count field.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester.
- count  in  NREQ*CNT_W  flattened pulse counts; field i = count[i*CNT_W +: CNT_W]; sampled only at grant.
- grant  out  NREQ  one-hot owner, held for the whole sequence.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at sequence end.
- led  out  1  LED drive.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, grant=0, busy=0, done=0, led=0, prescaler=0, phase counter=0, pulse counter=0, rr pointer=NREQ-1 (so req[0] has top priority first).
  - rst overrides everything mid-sequence: LED low next cycle, no done pulse.
- Eligibility: requester i is eligible iff req[i]=1 and count field i != 0. Zero-count requests are ignored and never granted.
- Arbitration, state IDLE:
  - Search eligible requesters starting at pointer+1, modulo NREQ.
  - On a hit at edge n, at edge n+1: state=ON, grant=onehot(i), led=1, busy=1, pointer=i.
  - The count is latched into the pulse counter. Prescaler and phase counter are cleared.
- Tick: prescaler counts 0..TICK_DIV-1 and wraps; tick=1 in the cycle it equals TICK_DIV-1. It is cleared on every phase entry, so each phase is an exact multiple of TICK_DIV cycles.
- ON (led=1): after ON_TICKS ticks, decrement the pulse counter.
  - If the result is != 0, go to OFF; otherwise go to GAP.
  - Duration: ON_TICKS*TICK_DIV cycles.
- OFF (led=0): after OFF_TICKS ticks, go to ON.
- GAP (led=0): after GAP_TICKS ticks, go to IDLE.
  - In that same cycle: done=1 for one cycle, grant=0, busy=0.
- Sequence length from grant to done: C*ON_TICKS*TICK_DIV + (C-1)*OFF_TICKS*TICK_DIV + GAP_TICKS*TICK_DIV cycles.
- Input stability:
  - Dropping req mid-sequence does not abort; the sequence completes and done still pulses.
  - Changing count mid-sequence has no effect.
- Re-arbitration: IDLE is always occupied for at least one cycle. A requester holding req after done competes again, but behind the others because of the round-robin pointer.
- Simultaneous requests: exactly one grant, per round-robin order. Others wait with no loss.
- Count C = 2^CNT_W-1 is legal. The pulse counter is CNT_W wide and never wraps, because it stops at 0.
- The phase counter is wide enough for max(ON_TICKS, OFF_TICKS, GAP_TICKS).

Decomposition:
- Shared package/include led_pkg:
  - state encodings IDLE/ON/OFF/GAP (2 bits);
  - the localparam clog2 helper for counter widths.
- One sub-module, led_tick_gen:
  - parameter TICK_DIV; ports clk, rst, clr, tick;
  - the same prescaler pattern as the existing blinker, with clear.
- The arbiter and FSM stay in led_code_arbiter.

Test Plan (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3, NREQ=4, CNT_W=4):
- Reset: hold rst 3 cycles with req=4'b1111 -> led=0, grant=0, busy=0, done=0 throughout; first grant is to req[0] one cycle after rst drops.
- Single code: req[2]=1, count2=3 -> grant=4'b0100 next cycle; led pattern 8 high, 4 low, 8 high, 4 low, 8 high, 12 low; done pulses at cycle 44 after grant, for one cycle.
- Round robin: req=4'b1011, all counts=1 -> grant order 0,1,3,0 with requests held; each sequence is 20 cycles; at least one IDLE cycle between grants.
- Zero count / drop: req[1]=1 with count1=0 -> never granted, busy stays 0. req[3] dropped 5 cycles into its sequence -> sequence still completes and done=1.
- Mid-sequence reset: rst asserted during second ON of count=3 -> next cycle led=0, grant=0, state IDLE, no done; the pointer returns to NREQ-1.
- Max count: count0=15 -> exactly 15 high pulses counted by the bench, then done.
